// File: rtl/bcd_digit_driver.sv
// Sequential double-dabble binary-to-BCD converter for the HEX digit decoders.
// Produces registered digit codes with leading-zero blanking and saturation.
module bcd_digit_driver #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] calc_max();
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = calc_max();

  state_t              state;
  logic [BIN_W-1:0]    sr;
  logic [BIN_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] disp;
  logic [CNT_W-1:0]    cnt;
  logic                sat;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  // Saturation is decided on the latched binary, since the BCD accumulator drops high digits.
  always_comb begin
    logic lead;
    sat  = 64'(bin_q) > MAX_VAL;
    disp = bcd;
    lead = 1'b1;
    if (sat) begin
      disp = {DIGITS{4'd9}};
    end else begin
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
        if (BLANK_LZ != 0 && lead && bcd[4*i +: 4] == 4'd0) disp[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digits   <= '1;
      sr       <= '0;
      bin_q    <= '0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= bin_in;
            sr    <= bin_in;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sr} <= {bcd_adj[4*DIGITS-2:0], sr, 1'b0};
          cnt       <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) state <= FINISH;
        end
        FINISH: begin
          digits   <= disp;
          overflow <= sat;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_driver.sv
// Directed and table-driven checks of bcd_digit_driver with and without blanking.
module tb_bcd_digit_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [15:0] dig0, dig1;

  int unsigned total = 0;
  int unsigned passed = 0;

  bcd_digit_driver #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy0), .done(done0), .overflow(ovf0), .digits(dig0)
  );

  bcd_digit_driver #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy1), .done(done1), .overflow(ovf1), .digits(dig1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          val;
    logic [15:0] exp_blank;
    logic [15:0] exp_plain;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [15:0] model(input int v, input bit blank);
    logic [3:0] d [4];
    if (v > 9999) return 16'h9999;
    d[0] = 4'(v % 10);
    d[1] = 4'((v / 10) % 10);
    d[2] = 4'((v / 100) % 10);
    d[3] = 4'(v / 1000);
    if (blank) begin
      for (int k = 3; k >= 1; k--) begin
        if (d[k] == 4'd0) d[k] = 4'hF;
        else break;
      end
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  // Pulse start for one accepted edge, then count cycles until done (bounded).
  task automatic convert(input int v, output int lat);
    @(negedge clk);
    bin_in = 14'(v);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done0 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  vec_t vecs [13];

  initial begin
    int lat;
    int c;
    int t [3];
    int nd;
    bit flicker;
    logic [15:0] prev;

    vecs[0]  = '{0,     16'hFFF0, 16'h0000, 1'b0};
    vecs[1]  = '{1234,  16'h1234, 16'h1234, 1'b0};
    vecs[2]  = '{7,     16'hFFF7, 16'h0007, 1'b0};
    vecs[3]  = '{100,   16'hF100, 16'h0100, 1'b0};
    vecs[4]  = '{10000, 16'h9999, 16'h9999, 1'b1};
    vecs[5]  = '{16383, 16'h9999, 16'h9999, 1'b1};
    vecs[6]  = '{9999,  16'h9999, 16'h9999, 1'b0};
    vecs[7]  = '{5,     16'hFFF5, 16'h0005, 1'b0};
    vecs[8]  = '{1000,  16'h1000, 16'h1000, 1'b0};
    vecs[9]  = '{10,    16'hFF10, 16'h0010, 1'b0};
    vecs[10] = '{305,   16'hF305, 16'h0305, 1'b0};
    vecs[11] = '{4095,  16'h4095, 16'h4095, 1'b0};
    vecs[12] = '{9,     16'hFFF9, 16'h0009, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_ovf", 32'(ovf0), 32'd0);
    check("reset_digits", 32'(dig0), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      convert(vecs[i].val, lat);
      check($sformatf("lat_%0d", vecs[i].val), 32'(lat), 32'd15);
      check($sformatf("dig_%0d", vecs[i].val), 32'(dig0), 32'(vecs[i].exp_blank));
      check($sformatf("ovf_%0d", vecs[i].val), 32'(ovf0), 32'(vecs[i].exp_ovf));
      check($sformatf("plain_%0d", vecs[i].val), 32'(dig1), 32'(vecs[i].exp_plain));
      check($sformatf("plain_ovf_%0d", vecs[i].val), 32'(ovf1), 32'(vecs[i].exp_ovf));
    end

    // Reset mid-SHIFT aborts and blanks
    convert(1234, lat);
    @(negedge clk);
    bin_in = 14'd77;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_mid_busy", 32'(busy0), 32'd0);
    check("rst_mid_done", 32'(done0), 32'd0);
    check("rst_mid_digits", 32'(dig0), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0) nd++;
    end
    check("rst_no_late_done", 32'(nd), 32'd0);

    // Continuous start: one conversion every 16 cycles
    @(negedge clk);
    bin_in = 14'd42;
    start  = 1'b1;
    c = 0;
    nd = 0;
    while (nd < 3 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
      if (done0) begin
        t[nd] = c;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    check("hold_done_count", 32'(nd), 32'd3);
    check("hold_first", 32'(t[0]), 32'd16);
    check("hold_period1", 32'(t[1] - t[0]), 32'd16);
    check("hold_period2", 32'(t[2] - t[1]), 32'd16);
    check("hold_digits", 32'(dig0), 32'hFF42);
    repeat (2) @(posedge clk);
    #1;
    check("hold_idle_busy", 32'(busy0), 32'd0);

    // Mid-SHIFT start pulse ignored, bin_in change not reflected, digits hold
    convert(1234, lat);
    @(negedge clk);
    bin_in = 14'd42;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    prev = dig0;
    flicker = 1'b0;
    lat = 0;
    while (!done0 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) begin
        bin_in = 14'd777;
        start  = 1'b1;
      end
      if (lat == 4) start = 1'b0;
      if (!done0 && dig0 !== prev) flicker = 1'b1;
    end
    check("mid_lat", 32'(lat), 32'd15);
    check("mid_digits", 32'(dig0), 32'hFF42);
    check("mid_no_flicker", 32'(flicker), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done0), 32'd0);
    nd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0) nd++;
    end
    check("mid_not_queued", 32'(nd), 32'd0);

    // Random sweep against the reference model
    for (int i = 0; i < 16; i++) begin
      int v;
      v = (i < 10) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      convert(v, lat);
      check($sformatf("rnd_blank_%0d", v), 32'(dig0), 32'(model(v, 1'b1)));
      check($sformatf("rnd_plain_%0d", v), 32'(dig1), 32'(model(v, 1'b0)));
      check($sformatf("rnd_ovf_%0d", v), 32'(ovf0), 32'(v > 9999));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
